// File: rtl/spad_req_queue.sv
// Scratchpad request queue: circular buffer whose youngest entries may be
// speculative, committed or squashed as a group when the guarding branch resolves.
module spad_req_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 38
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     wen,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     wspec,
  output logic                     full,
  input  logic                     ren,
  output logic                     rvalid,
  output logic [WIDTH-1:0]         rdata,
  input  logic                     resolve_commit,
  input  logic                     resolve_squash,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   spec_count,
  output logic                     err_overflow,
  output logic                     err_resolve
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW-1:0] spec_head_q, spec_head_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] spec_q, spec_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_res_q, err_res_d;

  logic          push_ok, pop_ok, push_wr, push_spec;
  logic          squash, commit;
  logic [AW-1:0] wr_ptr;

  assign full       = (count_q == CW'(DEPTH));
  assign rvalid     = (count_q != '0) && (count_q > spec_q);
  assign rdata      = (count_q != '0) ? mem_q[head_q] : '0;
  assign count      = count_q;
  assign spec_count = spec_q;
  assign err_overflow = err_ovf_q;
  assign err_resolve  = err_res_q;

  always_comb begin
    squash    = resolve_squash;
    commit    = resolve_commit & ~resolve_squash;
    push_ok   = wen & ~full;
    pop_ok    = ren & rvalid;
    // a speculative push racing a squash belongs to the discarded path
    push_wr   = push_ok & ~(squash & wspec);
    push_spec = push_ok & ~squash & ~commit & (wspec | (spec_q != '0));
    wr_ptr    = squash ? spec_head_q : tail_q;

    head_d  = head_q + AW'(pop_ok);
    tail_d  = wr_ptr + AW'(push_wr);
    count_d = count_q - (squash ? spec_q : '0) - CW'(pop_ok) + CW'(push_wr);
    spec_d  = (squash | commit) ? '0 : spec_q + CW'(push_spec);
    // with no speculative entries the speculative region starts at the tail
    spec_head_d = (spec_d == '0) ? tail_d : spec_head_q;

    err_ovf_d = err_ovf_q | (wen & full);
    err_res_d = err_res_q | (resolve_commit & resolve_squash);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q      <= '0;
      tail_q      <= '0;
      spec_head_q <= '0;
      count_q     <= '0;
      spec_q      <= '0;
      err_ovf_q   <= 1'b0;
      err_res_q   <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      spec_head_q <= spec_head_d;
      count_q     <= count_d;
      spec_q      <= spec_d;
      err_ovf_q   <= err_ovf_d;
      err_res_q   <= err_res_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_wr) mem_q[wr_ptr] <= wdata;
  end
endmodule

// File: tb/tb_spad_req_queue.sv
// Bench for spad_req_queue (DEPTH=4): queue-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_spad_req_queue;
  localparam int DEPTH = 4;
  localparam int WIDTH = 38;

  logic             CLK, nRST;
  logic             wen, wspec, ren, resolve_commit, resolve_squash;
  logic [WIDTH-1:0] wdata;
  logic             full, rvalid, err_overflow, err_resolve;
  logic [WIDTH-1:0] rdata;
  logic [2:0]       count, spec_count;

  int checks = 0;
  int errors = 0;

  spad_req_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .nRST(nRST), .wen(wen), .wdata(wdata), .wspec(wspec),
    .full(full), .ren(ren), .rvalid(rvalid), .rdata(rdata),
    .resolve_commit(resolve_commit), .resolve_squash(resolve_squash),
    .count(count), .spec_count(spec_count),
    .err_overflow(err_overflow), .err_resolve(err_resolve)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input int op, input int rd, input logic [31:0] a);
    logic [1:0] o;
    logic [3:0] r;
    o = 2'(op);
    r = 4'(rd);
    return {o, r, a};
  endfunction

  // Reference model: oldest-first list of entries; the youngest mspec are speculative.
  logic [WIDTH-1:0] mq[$];
  int  mspec = 0;
  bit  movf = 0, mres = 0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mq.delete();
      mspec = 0;
      movf  = 0;
      mres  = 0;
    end else begin
      bit fm, rv, pu, po;
      fm = (mq.size() == DEPTH);
      rv = (mq.size() > mspec);
      pu = wen && !fm;
      po = ren && rv;
      if (wen && fm) movf = 1;
      if (resolve_commit && resolve_squash) mres = 1;
      if (po) void'(mq.pop_front());
      if (resolve_squash) begin
        repeat (mspec) void'(mq.pop_back());
        mspec = 0;
        if (pu && !wspec) mq.push_back(wdata);
      end else if (resolve_commit) begin
        mspec = 0;
        if (pu) mq.push_back(wdata);
      end else if (pu) begin
        if (wspec || mspec > 0) mspec++;
        mq.push_back(wdata);
      end
    end
  end

  always @(negedge CLK) begin
    chk("count", count, mq.size());
    chk("spec_count", spec_count, mspec);
    chk("full", full, mq.size() == DEPTH);
    chk("rvalid", rvalid, mq.size() > mspec);
    chk("rdata", rdata, mq.size() > 0 ? mq[0] : '0);
    chk("err_overflow", err_overflow, movf);
    chk("err_resolve", err_resolve, mres);
  end

  task automatic drv(input logic w, input logic [WIDTH-1:0] d, input logic s,
                     input logic r, input logic c, input logic q);
    wen = w; wdata = d; wspec = s; ren = r; resolve_commit = c; resolve_squash = q;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    wen = 0; wspec = 0; ren = 0; resolve_commit = 0; resolve_squash = 0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input logic s);
    drv(1, d, s, 0, 0, 0);
  endtask

  task automatic pop();
    drv(0, '0, 0, 1, 0, 0);
  endtask

  task automatic do_reset();
    #1 nRST = 0;
    @(negedge CLK);
    #1 nRST = 1;
  endtask

  logic [WIDTH-1:0] a, b, c, d, e;

  initial begin
    nRST = 1; wen = 0; wspec = 0; ren = 0; resolve_commit = 0; resolve_squash = 0;
    wdata = '0;
    #1 nRST = 0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_count", count, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_full", full, 0);
    nRST = 1;

    // fill, overflow, drain in order
    a = mk(1, 0, 32'h1000); b = mk(1, 0, 32'h2000);
    c = mk(1, 0, 32'h3000); d = mk(1, 0, 32'h4000); e = mk(1, 0, 32'h5000);
    chk("mk_literal", a, 38'h10_0000_1000);
    push(a, 0); push(b, 0); push(c, 0); push(d, 0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    drv(1, e, 0, 1, 0, 0);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_count", count, 3);
    chk("ovf_head", rdata, b);
    pop(); chk("drain_c", rdata, c);
    pop(); chk("drain_d", rdata, d);
    pop();
    chk("drain_rvalid", rvalid, 0);
    chk("drain_count", count, 0);

    // commit path
    a = mk(1, 1, 32'h100); b = mk(2, 2, 32'h200); c = mk(3, 3, 32'h300);
    push(a, 0); push(b, 1); push(c, 0);
    chk("spec_count3", count, 3);
    chk("spec_spec2", spec_count, 2);
    chk("spec_rvalid", rvalid, 1);
    pop();
    chk("spec_blocked", rvalid, 0);
    chk("spec_count2", count, 2);
    drv(0, '0, 0, 0, 1, 0);
    chk("commit_rvalid", rvalid, 1);
    chk("commit_rdata", rdata, b);
    pop(); pop();

    // squash with same-cycle committed push
    d = mk(1, 4, 32'h400);
    push(a, 0); push(b, 1); push(c, 1);
    drv(1, d, 0, 0, 0, 1);
    chk("sq_count", count, 2);
    chk("sq_spec", spec_count, 0);
    chk("sq_first", rdata, a);
    pop();
    chk("sq_second", rdata, d);
    pop();

    // squash of a wrapped speculative region
    do_reset();
    push(mk(1, 0, 32'h10), 0); push(mk(1, 0, 32'h11), 0); push(mk(1, 0, 32'h12), 0);
    pop(); pop();
    push(mk(2, 0, 32'h13), 1); push(mk(2, 0, 32'h14), 1);
    chk("wrap_spec", spec_count, 2);
    drv(0, '0, 0, 0, 0, 1);
    chk("wrap_count", count, 1);
    chk("wrap_tail", dut.tail_q, 3);
    push(mk(1, 5, 32'h15), 0);
    chk("wrap_slot3", dut.mem_q[3], mk(1, 5, 32'h15));
    pop();
    chk("wrap_next", rdata, mk(1, 5, 32'h15));
    pop();

    // commit+squash together
    push(a, 0); push(b, 1);
    drv(0, '0, 0, 0, 1, 1);
    chk("both_count", count, 1);
    chk("both_err", err_resolve, 1);
    pop();

    // commit with speculative push, squash with speculative push, squash with pop
    push(a, 1);
    drv(1, b, 1, 0, 1, 0);
    chk("cpush_spec", spec_count, 0);
    chk("cpush_count", count, 2);
    pop(); pop();
    push(a, 1);
    drv(1, b, 1, 0, 0, 1);
    chk("sqspec_drop", count, 0);
    push(a, 0); push(b, 1);
    drv(0, '0, 0, 1, 0, 1);
    chk("sqpop_count", count, 0);

    // asynchronous reset mid-burst
    push(a, 0); push(b, 0); push(c, 0);
    chk("pre_rst_count", count, 3);
    #2 nRST = 0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_rvalid", rvalid, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_flags", {err_overflow, err_resolve}, 0);
    @(negedge CLK);
    #1 nRST = 1;
    push(e, 0);
    chk("post_rst_rdata", rdata, e);
    chk("post_rst_rvalid", rvalid, 1);

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [63:0] r;
      r = {$urandom, $urandom};
      drv(($urandom % 3) != 0, r[WIDTH-1:0], ($urandom % 4) == 0, ($urandom % 2) == 0,
          ($urandom % 9) == 0, ($urandom % 11) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spad_req_queue.md
SPAD_REQ_QUEUE -- requirements
Module: spad_req_queue

Interface
REQ-001 Parameter DEPTH, default 8, entry count; SHALL be a power of two, 2..64.
REQ-002 Parameter WIDTH, default 38, entry bits: {op[1:0] (01 load, 10 store, 11 gemm), matrix_rd[3:0], addr/gemm-select[31:0]}.
REQ-003 CLK  in  1  sole clock, rising edge.
REQ-004 nRST  in  1  asynchronous, active-low reset.
REQ-005 wen  in  1  push request.
REQ-006 wdata  in  WIDTH  push payload.
REQ-007 wspec  in  1  push is speculative (behind an unresolved branch).
REQ-008 full  out  1  count == DEPTH.
REQ-009 ren  in  1  pop request.
REQ-010 rvalid  out  1  head entry present and non-speculative.
REQ-011 rdata  out  WIDTH  head entry payload.
REQ-012 resolve_commit  in  1  branch resolved correct; all speculative entries become committed.
REQ-013 resolve_squash  in  1  branch mispredicted; all speculative entries discarded.
REQ-014 count  out  $clog2(DEPTH)+1  valid entries.
REQ-015 spec_count  out  $clog2(DEPTH)+1  speculative entries.
REQ-016 err_overflow  out  1  sticky: push attempted while full.
REQ-017 err_resolve  out  1  sticky: commit and squash asserted together.

Function
REQ-018 Storage SHALL be a circular buffer with head, tail and spec_head pointers; wrap from DEPTH-1 to 0.
REQ-019 Speculative entries SHALL always be the youngest, contiguous from spec_head to tail-1.
REQ-020 Push accepted iff wen=1 and full=0, evaluated on pre-edge state; entry written at tail, tail+1, count+1 on the edge.
REQ-021 Push with full=1 SHALL be dropped and set err_overflow; a same-cycle pop does not make room.
REQ-022 Accepted push SHALL be speculative if wspec=1 or spec_count>0 (pre-edge); a speculative push increments spec_count.
REQ-023 rdata SHALL be combinational from the head slot when count>0, else 0; rvalid = (count>0) and (count>spec_count).
REQ-024 Pop accepted iff ren=1 and rvalid=1: head+1, count-1 on the edge; ren with rvalid=0 ignored, no error.
REQ-025 Push and pop in the same cycle on a non-full, non-empty queue: both SHALL take effect; count unchanged.
REQ-026 resolve_commit SHALL set spec_count to 0 on the edge; a same-cycle accepted push is committed (not speculative).
REQ-027 resolve_squash SHALL set tail to spec_head, count to count - spec_count, spec_count to 0 on the edge.
REQ-028 On squash, same-cycle push with wspec=1 SHALL be dropped; with wspec=0 it SHALL be written at the rewound tail as committed.
REQ-029 Squash with a same-cycle accepted pop: both apply; pop only ever removes a committed entry.
REQ-030 Commit and squash together: squash SHALL win and err_resolve SHALL set.
REQ-031 While spec_count=0, spec_head SHALL track tail.
REQ-032 Latency: pushed committed entry visible on rdata/rvalid the cycle after the push edge; no bypass from wdata.
REQ-033 full/count/spec_count SHALL be registered-state derived, glitch-free, updated only on CLK edges.
REQ-034 Error flags SHALL clear only on reset.

Reset
REQ-035 nRST=0 SHALL asynchronously clear head, tail, spec_head, count, spec_count, err_overflow, err_resolve; full=0, rvalid=0, rdata=0.
REQ-036 Storage contents SHALL NOT require reset.
REQ-037 Reset mid-operation SHALL discard all entries; first post-reset push lands in slot 0.

Verification
REQ-038 DEPTH=4: push 0x1_0_00001000..0x1_0_00004000 committed -> full=1, count=4; 5th push -> dropped, err_overflow=1; pop x4 -> same order, rvalid=0.
REQ-039 Push A committed, B/C wspec=1 -> count=3, spec_count=2, rvalid=1; pop A -> rvalid=0 with count=2; resolve_commit -> rvalid=1, rdata=B.
REQ-040 Push A committed, B/C spec, then resolve_squash with same-cycle push D wspec=0 -> count=2, entries A,D; pops yield A then D.
REQ-041 Tail at slot 3 with 2 spec entries wrapped (slots 3,0), squash -> tail=3, count excludes both; next push lands in slot 3.
REQ-042 resolve_commit and resolve_squash same cycle with 1 spec entry -> entry removed, err_resolve=1.
REQ-043 nRST low mid-burst with count=3 -> count=0, rvalid=0, rdata=0 immediately, flags clear; push after release readable next cycle.
